// File: rtl/red_pkg.sv
// Shared types and constants for the RED nibble-reduction sequencer.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } red_state_t;

    localparam int RED_NIBBLES = 8;
    localparam int RED_ACC_W   = 8;
    localparam int RED_DATA_W  = 16;

endpackage

// File: rtl/red_nib_sel.sv
// Selects nibble idx from the latched {src2,src1} operand pair.
module red_nib_sel
    import red_pkg::*;
(
    input  logic [2*RED_DATA_W-1:0] ops,
    input  logic [2:0]              idx,
    output logic [3:0]              nib,
    output logic                    sign
);

    always_comb begin
        nib  = ops[{idx, 2'b00} +: 4];
        sign = nib[3];
    end

endmodule

// File: rtl/red_seq_ctrl.sv
// RED sequencer: sums eight signed nibbles over a shared external 4-bit slice.
// Optional RED_ZERO_SKIP_EN: zero nibbles retire in one cycle instead of two.
module red_seq_ctrl
    import red_pkg::*;
#(
    parameter int DATA_W = RED_DATA_W,
    parameter int ACC_W  = RED_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] red_result,
    output logic [3:0]        cla_a,
    output logic [3:0]        cla_b,
    output logic              cla_cin,
    input  logic [4:0]        cla_s
);

    red_state_t          state;
    red_state_t          state_nx;
    logic [2*DATA_W-1:0] ops;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_fin;
    logic                carry;
    logic [2:0]          idx;
    logic [3:0]          nib;
    logic                sign;
    logic                last;
    logic                skip;

    red_nib_sel u_nib_sel (
        .ops  (ops),
        .idx  (idx),
        .nib  (nib),
        .sign (sign)
    );

    assign last = (idx == 3'(RED_NIBBLES - 1));

`ifdef RED_ZERO_SKIP_EN
    assign skip = (nib == 4'h0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nx = LO;
                LO: begin
                    if (!skip)     state_nx = HI;
                    else if (last) state_nx = DONE;
                    else           state_nx = LO;
                end
                HI:   state_nx = last ? DONE : LO;
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        cla_a   = 4'h0;
        cla_b   = 4'h0;
        cla_cin = 1'b0;
        unique case (state)
            LO: begin
                cla_a = acc[3:0];
                cla_b = nib;
            end
            HI: begin
                cla_a   = acc[7:4];
                cla_b   = {4{sign}};
                cla_cin = carry;
            end
            default: ;
        endcase
    end

    // The final HI pass commits its upper nibble in the same edge as the result.
    assign acc_fin = (state == HI) ? {cla_s[3:0], acc[3:0]} : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops        <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            idx        <= 3'd0;
            red_result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        ops   <= {src2, src1};
                        acc   <= '0;
                        carry <= 1'b0;
                        idx   <= 3'd0;
                    end
                end
                LO: begin
                    if (skip) begin
                        if (!last) idx <= idx + 3'd1;
                    end else begin
                        acc[3:0] <= cla_s[3:0];
                        carry    <= cla_s[4];
                    end
                end
                HI: begin
                    acc[7:4] <= cla_s[3:0];
                    if (!last) idx <= idx + 3'd1;
                end
                default: ;
            endcase
            if (state_nx == DONE && state != DONE) begin
                red_result <= {{(DATA_W-ACC_W){acc_fin[ACC_W-1]}}, acc_fin};
            end
        end
    end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Directed self-checking bench for red_seq_ctrl with a behavioural 4-bit slice.
`timescale 1ns/1ps
module tb_red_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic        busy;
    logic        done;
    logic [15:0] red_result;
    logic [3:0]  cla_a;
    logic [3:0]  cla_b;
    logic        cla_cin;
    logic [4:0]  cla_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cla_s = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

    red_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .src1       (src1),
        .src2       (src2),
        .busy       (busy),
        .done       (done),
        .red_result (red_result),
        .cla_a      (cla_a),
        .cla_b      (cla_b),
        .cla_cin    (cla_cin),
        .cla_s      (cla_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle in which done is expected, counting the start edge as cycle 0.
    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] v;
        int n;
        v = {b, a};
        n = 0;
`ifdef RED_ZERO_SKIP_EN
        for (int i = 0; i < 8; i++) n += (v[i*4 +: 4] == 4'h0) ? 1 : 2;
`else
        n = 16;
`endif
        return 1 + n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] s1, input logic [15:0] s2,
                          input logic [15:0] exp_res, input string tag);
        int cyc;
        src1  = s1;
        src2  = s2;
        start = 1'b1;
        tick();
        start = 1'b0;
        src1  = 16'hDEAD;
        src2  = 16'hBEEF;
        cyc   = 1;
        while (!done && cyc < 40) begin
            check({tag, "_busy"}, {31'b0, busy}, 32'd1);
            tick();
            cyc++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_lat"}, cyc, exp_lat(s1, s2));
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        check({tag, "_result"}, {16'b0, red_result}, {16'b0, exp_res});
        tick();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_hold"}, {16'b0, red_result}, {16'b0, exp_res});
    endtask

    initial begin
        int ndone;
        int dcyc;

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", {16'b0, red_result}, 32'h0);
        check("rst_cla", {23'b0, cla_a, cla_b, cla_cin}, 32'h0);

        run_op(16'h0000, 16'h0000, 16'h0000, "zero");
        run_op(16'h1111, 16'h1111, 16'h0008, "ones");
        run_op(16'h7777, 16'h7777, 16'h0038, "max");
        run_op(16'h8888, 16'h8888, 16'hFFC0, "min");

        // Second start in cycle 5 with different operands must be ignored.
        src1  = 16'h00F1;
        src2  = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        dcyc  = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                ndone++;
                dcyc = c;
                check("ign_result", {16'b0, red_result}, 32'h0);
            end
            if (c == 5) begin
                start = 1'b1;
                src1  = 16'h7777;
                src2  = 16'h7777;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("ign_ndone", ndone, 1);
        check("ign_cycle", dcyc, exp_lat(16'h00F1, 16'h0000));
        check("ign_final", {16'b0, red_result}, 32'h0);

        // Flush in cycle 6: no done, result untouched.
        src1  = 16'h1111;
        src2  = 16'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lo_cla", {23'b0, cla_a, cla_b, cla_cin}, {23'b0, 4'h0, 4'h1, 1'b0});
        tick();
        check("hi_cla", {23'b0, cla_a, cla_b, cla_cin}, 32'h0);
        tick();
        check("lo2_cla", {23'b0, cla_a, cla_b, cla_cin}, {23'b0, 4'h1, 4'h1, 1'b0});
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) ndone++;
            tick();
        end
        check("flush_ndone", ndone, 0);
        check("flush_result", {16'b0, red_result}, 32'h0);

        // Build a nonzero result, then reset in cycle 9 of the next operation.
        run_op(16'h7777, 16'h7777, 16'h0038, "pre_rst");
        src1  = 16'h1111;
        src2  = 16'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_result", {16'b0, red_result}, 32'h0);
        check("mid_rst_cla", {23'b0, cla_a, cla_b, cla_cin}, 32'h0);

        run_op(16'h0001, 16'h0000, 16'h0001, "skip");
        run_op(16'hF00F, 16'h0110, 16'h0000, "mixed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
